// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - raster sweep of a WIDTH x HEIGHT sprite box onto the VGA write port (optional SPRITE_PLOTTER_CLIP_EN)
module sprite_plotter #(
    parameter int         WIDTH     = 8,
    parameter int         HEIGHT    = 8,
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic       erase,
    output logic       busy,
    output logic       done,
    output logic       plot,
    output logic [7:0] px_x,
    output logic [6:0] px_y,
    output logic [2:0] colour
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [3:0] COL_LAST = 4'(WIDTH - 1);
    localparam logic [3:0] ROW_LAST = 4'(HEIGHT - 1);

    state_t     state_q, state_d;
    logic [7:0] x0_q, x0_d;
    logic [6:0] y0_q, y0_d;
    logic [3:0] col_q, col_d;
    logic [3:0] row_q, row_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       plot_q, plot_d;
    logic [7:0] px_x_q, px_x_d;
    logic [6:0] px_y_q, px_y_d;
    logic [2:0] colour_q, colour_d;

    // Counters hold the pixel currently on the outputs; emit_* is the pixel
    // registered at this edge (pixel 0 when launching from IDLE).
    logic       last_col, last_pix;
    logic [3:0] col_nxt, row_nxt;
    logic [3:0] emit_col, emit_row;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic       in_view;

`ifdef SPRITE_PLOTTER_CLIP_EN
    localparam logic [8:0] SCREEN_W_L = 9'(SCREEN_W);
    localparam logic [7:0] SCREEN_H_L = 8'(SCREEN_H);
    logic [8:0] sum_x;
    logic [7:0] sum_y;
`else
    logic [7:0] sum_x;
    logic [6:0] sum_y;
`endif

    // Next pixel address and its screen coordinate
    always_comb begin
        last_col = (col_q == COL_LAST);
        last_pix = last_col && (row_q == ROW_LAST);
        col_nxt  = last_col ? 4'd0 : col_q + 4'd1;
        row_nxt  = last_col ? row_q + 4'd1 : row_q;
        emit_col = (state_q == S_IDLE) ? 4'd0 : col_nxt;
        emit_row = (state_q == S_IDLE) ? 4'd0 : row_nxt;
        base_x   = (state_q == S_IDLE) ? x_in : x0_q;
        base_y   = (state_q == S_IDLE) ? y_in : y0_q;
`ifdef SPRITE_PLOTTER_CLIP_EN
        sum_x    = {1'b0, base_x} + {5'b0, emit_col};
        sum_y    = {1'b0, base_y} + {4'b0, emit_row};
        in_view  = (sum_x < SCREEN_W_L) && (sum_y < SCREEN_H_L);
`else
        sum_x    = base_x + {4'b0, emit_col};
        sum_y    = base_y + {3'b0, emit_row};
        in_view  = 1'b1;
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        col_d    = col_q;
        row_d    = row_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        plot_d   = 1'b0;
        px_x_d   = px_x_q;
        px_y_d   = px_y_q;
        colour_d = colour_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_DRAW;
                    x0_d     = x_in;
                    y0_d     = y_in;
                    colour_d = erase ? BG_COLOUR : FG_COLOUR;
                    col_d    = 4'd0;
                    row_d    = 4'd0;
                    busy_d   = 1'b1;
                    plot_d   = in_view;
                    px_x_d   = sum_x[7:0];
                    px_y_d   = sum_y[6:0];
                end
            end
            S_DRAW: begin
                busy_d = 1'b1;
                if (last_pix) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    col_d  = col_nxt;
                    row_d  = row_nxt;
                    plot_d = in_view;
                    px_x_d = sum_x[7:0];
                    px_y_d = sum_y[6:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            x0_q     <= 8'd0;
            y0_q     <= 7'd0;
            col_q    <= 4'd0;
            row_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            px_x_q   <= 8'd0;
            px_y_q   <= 7'd0;
            colour_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            col_q    <= col_d;
            row_q    <= row_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            plot_q   <= plot_d;
            px_x_q   <= px_x_d;
            px_y_q   <= px_y_d;
            colour_q <= colour_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign plot   = plot_q;
    assign px_x   = px_x_q;
    assign px_y   = px_y_q;
    assign colour = colour_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// tb/tb_sprite_plotter.sv - directed vector bench for sprite_plotter
module tb_sprite_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic       erase;
    logic       busy, done, plot;
    logic [7:0] px_x;
    logic [6:0] px_y;
    logic [2:0] colour;

    int n_tests = 0;
    int n_fail  = 0;

    sprite_plotter dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .x_in   (x_in),
        .y_in   (y_in),
        .erase  (erase),
        .busy   (busy),
        .done   (done),
        .plot   (plot),
        .px_x   (px_x),
        .px_y   (px_y),
        .colour (colour)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic       er;
        int         exp_cnt;
        logic [7:0] fx;
        logic [6:0] fy;
        logic [7:0] lx;
        logic [6:0] ly;
        logic [2:0] col;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sweep(input int idx, input vec_t v);
        logic [7:0] sx[64];
        logic [6:0] sy[64];
        int n = 0, ndone = 0, done_at = -1, outside = 0, badcol = 0, busybad = 0;
        logic [6:0] y9;
        @(negedge clk);
        x_in = v.x; y_in = v.y; erase = v.er; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; x_in = ~v.x; y_in = ~v.y; erase = ~v.er;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (plot) begin
                if (c > 64) outside++;
                if (n < 64) begin
                    sx[n] = px_x;
                    sy[n] = px_y;
                end
                n++;
                if (colour != v.col) badcol++;
            end
            if (done) begin
                ndone++;
                done_at = c;
            end
            if (busy != (c <= 65)) busybad++;
        end
        chk($sformatf("v%0d plot_count", idx), n, v.exp_cnt);
        chk($sformatf("v%0d done_count", idx), ndone, 1);
        chk($sformatf("v%0d done_cycle", idx), done_at, 65);
        chk($sformatf("v%0d plot_outside_window", idx), outside, 0);
        chk($sformatf("v%0d colour_errors", idx), badcol, 0);
        chk($sformatf("v%0d busy_errors", idx), busybad, 0);
        if (n > 0 && n <= 64 && v.exp_cnt > 0) begin
            chk($sformatf("v%0d first_x", idx), int'(sx[0]), int'(v.fx));
            chk($sformatf("v%0d first_y", idx), int'(sy[0]), int'(v.fy));
            chk($sformatf("v%0d last_x", idx), int'(sx[n-1]), int'(v.lx));
            chk($sformatf("v%0d last_y", idx), int'(sy[n-1]), int'(v.ly));
        end
        if (n == 64 && v.exp_cnt == 64) begin
            y9 = v.fy + 7'd1;
            chk($sformatf("v%0d ninth_x", idx), int'(sx[8]), int'(v.fx));
            chk($sformatf("v%0d ninth_y", idx), int'(sy[8]), int'(y9));
        end
    endtask

    initial begin
        int nplot, ndone, done_at, badx;
        int dtimes[8];

        vecs[0] = '{8'd60,  7'd20,  1'b0, 64, 8'd60,  7'd20,  8'd67,  7'd27,  3'b111};
        vecs[1] = '{8'd60,  7'd20,  1'b1, 64, 8'd60,  7'd20,  8'd67,  7'd27,  3'b000};
`ifdef SPRITE_PLOTTER_CLIP_EN
        vecs[2] = '{8'd156, 7'd118, 1'b0, 8,  8'd156, 7'd118, 8'd159, 7'd119, 3'b111};
        vecs[3] = '{8'd252, 7'd124, 1'b1, 0,  8'd0,   7'd0,   8'd0,   7'd0,   3'b000};
`else
        vecs[2] = '{8'd156, 7'd118, 1'b0, 64, 8'd156, 7'd118, 8'd163, 7'd125, 3'b111};
        vecs[3] = '{8'd252, 7'd124, 1'b1, 64, 8'd252, 7'd124, 8'd3,   7'd3,   3'b000};
`endif
        vecs[4] = '{8'd0,   7'd0,   1'b0, 64, 8'd0,   7'd0,   8'd7,   7'd7,   3'b111};

        reset = 1'b1; start = 1'b0; x_in = 8'd0; y_in = 7'd0; erase = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset plot", int'(plot), 0);
        chk("reset px_x", int'(px_x), 0);
        chk("reset px_y", int'(px_y), 0);
        chk("reset colour", int'(colour), 0);

        for (int i = 0; i < 5; i++) begin
            sweep(i, vecs[i]);
        end

        // Reset mid-sweep abandons it with no done pulse
        @(negedge clk);
        x_in = 8'd60; y_in = 7'd20; erase = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midreset plot", int'(plot), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset done", int'(done), 0);
        nplot = 0; ndone = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (plot) nplot++;
            if (done) ndone++;
        end
        chk("midreset later plots", nplot, 0);
        chk("midreset later dones", ndone, 0);

        // Start during a sweep is ignored; start at k+66 accepted
        @(negedge clk);
        x_in = 8'd60; y_in = 7'd20; erase = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nplot = 0; done_at = -1; badx = 0;
        for (int c = 1; c <= 67; c++) begin
            @(negedge clk);
            if (c <= 64) begin
                if (plot) nplot++;
                if (plot && (px_x < 8'd60 || px_x > 8'd67)) badx++;
            end
            if (done) done_at = c;
            if (c == 66) begin
                chk("restart c66 plot", int'(plot), 0);
                chk("restart c66 busy", int'(busy), 0);
            end
            if (c == 67) begin
                chk("restart c67 plot", int'(plot), 1);
                chk("restart c67 px_x", int'(px_x), 0);
                chk("restart c67 px_y", int'(px_y), 0);
            end
            start = (c == 10) || (c == 66);
            if (c >= 10) begin
                x_in = 8'd0; y_in = 7'd0;
            end
        end
        start = 1'b0;
        chk("ignored start plots", nplot, 64);
        chk("ignored start x range", badx, 0);
        chk("ignored start done", done_at, 65);
        repeat (80) @(negedge clk);

        // Start held high re-triggers every 66 cycles
        @(negedge clk);
        x_in = 8'd60; y_in = 7'd20; erase = 1'b0; start = 1'b1;
        ndone = 0;
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            if (done && ndone < 8) begin
                dtimes[ndone] = c;
                ndone++;
            end
        end
        start = 1'b0;
        chk("continuous done count", ndone, 3);
        if (ndone >= 3) begin
            chk("continuous spacing 1", dtimes[1] - dtimes[0], 66);
            chk("continuous spacing 2", dtimes[2] - dtimes[1], 66);
        end
        repeat (80) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
